// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-outstanding word reads to instruction memory
// and presents one fetched word with its PC to the decoder until it is accepted.

module instr_fetch_chk (
  input logic clk_i,
  input logic rst_i,
  input logic rvalid_i,
  input logic rvalid_ok_i
);

  // A response may only arrive while a read is outstanding.
  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i) rvalid_i |-> rvalid_ok_i)
    else $error("instr_fetch: imem_rvalid_i outside WAIT/FLUSH");

endmodule

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FLUSH = 3'd4
  } state_e;

  state_e      state_r;
  logic [31:0] pc_r;
  logic [31:0] redirect_pc_s;
  logic        rvalid_ok_s;

  assign redirect_pc_s = {redirect_pc_i[31:2], 2'b00};
  assign imem_req_o    = (state_r == REQ);
  assign imem_addr_o   = pc_r;
  assign rvalid_ok_s   = (state_r == WAIT) || (state_r == FLUSH);

  // Fetch sequencing, redirect handling and the registered decoder-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      instr_valid_o <= 1'b0;
      instr_o       <= 32'h0000_0000;
      pc_o          <= RESET_PC;
      misalign_o    <= 1'b0;
    end else if (redirect_i && (state_r != IDLE)) begin
      pc_r          <= redirect_pc_s;
      instr_valid_o <= 1'b0;
      misalign_o    <= |redirect_pc_i[1:0];
      // A read granted now, or still in flight, must have its response swallowed.
      // A response arriving with the redirect is itself the one being dropped.
      case (state_r)
        REQ:     state_r <= imem_gnt_i ? FLUSH : REQ;
        WAIT:    state_r <= imem_rvalid_i ? REQ : FLUSH;
        HOLD:    state_r <= REQ;
        FLUSH:   state_r <= imem_rvalid_i ? REQ : FLUSH;
        default: state_r <= IDLE;
      endcase
    end else begin
      misalign_o <= 1'b0;
      case (state_r)
        IDLE: state_r <= REQ;
        REQ: begin
          if (imem_gnt_i) state_r <= WAIT;
          else            state_r <= REQ;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            instr_o       <= imem_rdata_i;
            pc_o          <= pc_r;
            instr_valid_o <= 1'b1;
            state_r       <= HOLD;
          end else begin
            state_r <= WAIT;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            instr_valid_o <= 1'b0;
            pc_r          <= pc_r + 32'd4;
            state_r       <= REQ;
          end else begin
            state_r <= HOLD;
          end
        end
        FLUSH: begin
          if (imem_rvalid_i) state_r <= REQ;
          else               state_r <= FLUSH;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  instr_fetch_chk u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rvalid_i    (imem_rvalid_i),
    .rvalid_ok_i (rvalid_ok_s)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: acts as instruction memory and checks the fetch unit against
// a transaction-level model (architectural PC, one pending read, one held word).
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, req, gnt, rvalid, stall, redir, valid, mis;
  logic [31:0] addr, rdata, rpc, instr, pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
    .instr_valid_o(valid), .instr_o(instr), .pc_o(pc), .misalign_o(mis)
  );

  // model: next architectural fetch PC, one pending read, one held word
  bit          m_started = 1'b0;
  bit          m_rst_q = 1'b0;
  bit          m_pend = 1'b0, m_stale = 1'b0, m_hold = 1'b0, m_mis = 1'b0;
  logic [31:0] m_pc = RST_PC, m_paddr = 32'h0, m_hinstr = 32'h0, m_hpc = 32'h0;
  int          m_cnt = 0;
  int          gnt_pct = 100;
  int          dly_max = 1;
  // DUT outputs seen at the last sample point, for the hand-computed checks
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1300_0000 ^ (a * 32'h9E37_79B9);
  endfunction

  function automatic bit model_req();
    return !m_rst_q && !m_pend && !m_hold;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, drive inputs, advance the model.
  task automatic cyc(input bit r, input bit rd, input logic [31:0] rp, input bit st);
    bit m_req, granted, deliv;
    @(negedge clk);
    s_req = req; s_addr = addr; s_valid = valid; s_pc = pc; s_instr = instr; s_mis = mis;
    m_req = model_req();
    if (m_started) begin
      if (m_rst_q) begin
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, RST_PC);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_misalign", 32'(mis), 32'd0);
      end else begin
        chk("req", 32'(req), 32'(m_req));
        if (m_req) chk("addr", addr, m_pc);
        chk("valid", 32'(valid), 32'(m_hold));
        if (m_hold) begin
          chk("instr", instr, m_hinstr);
          chk("pc", pc, m_hpc);
        end
        chk("misalign", 32'(mis), 32'(m_mis));
      end
    end
    rst = r; redir = rd; rpc = rp; stall = st;
    gnt = ($urandom_range(99) < gnt_pct);
    rvalid = m_pend && (m_cnt == 0);
    rdata = rvalid ? mem_word(m_paddr) : $urandom();
    @(posedge clk);
    granted = m_req && gnt;
    deliv = rvalid;
    if (r) begin
      m_started = 1'b1; m_rst_q = 1'b1; m_pc = RST_PC;
      m_pend = 1'b0; m_hold = 1'b0; m_mis = 1'b0;
    end else if (m_rst_q) begin
      m_rst_q = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (m_pend && !deliv) m_cnt--;
      if (rd) begin
        m_pc = {rp[31:2], 2'b00};
        m_mis = |rp[1:0];
        m_hold = 1'b0;
        if (deliv) m_pend = 1'b0;
        else if (m_pend) m_stale = 1'b1;
        if (granted) begin
          m_pend = 1'b1; m_stale = 1'b1; m_paddr = m_pc;
          m_cnt = $urandom_range(dly_max - 1);
        end
      end else begin
        if (deliv) begin
          m_pend = 1'b0;
          if (!m_stale) begin
            m_hold = 1'b1; m_hinstr = mem_word(m_paddr); m_hpc = m_paddr;
          end
        end else if (m_hold && !st) begin
          m_hold = 1'b0;
          m_pc = m_pc + 32'd4;
        end
        if (granted) begin
          m_pend = 1'b1; m_stale = 1'b0; m_paddr = m_pc;
          m_cnt = $urandom_range(dly_max - 1);
        end
      end
    end
  endtask

  // Run idle cycles until the model reaches pending (what=1) or holding (what=2).
  task automatic run_until(input int what, input string name);
    int n;
    n = 0;
    while (!((what == 1) ? m_pend : m_hold) && n < 20) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    chk({name, "_reached"}, 32'(n < 20), 32'd1);
  endtask

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    stall = 1'b0; redir = 1'b0; rpc = 32'h0;

    // back-to-back fetch, grant at once, response one cycle later
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t1_valid", 32'(s_valid), 32'((i > 0) && (i % 3 == 0)));
      if (i == 3) begin
        chk("t1_pc0", s_pc, 32'h0);
        chk("t1_instr0", s_instr, 32'h1300_0000);
      end
      if (i == 6) chk("t1_pc4", s_pc, 32'h4);
      if (i == 9) chk("t1_pc8", s_pc, 32'h8);
      if (i == 4) chk("t1_addr4", s_addr, 32'h4);
    end

    // five stall cycles while holding
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    run_until(2, "t2_hold");
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, 32'h0, k < 5);
      chk("t2_valid", 32'(s_valid), 32'd1);
      chk("t2_pc", s_pc, 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_req", 32'(s_req), 32'd1);
    chk("t2_addr", s_addr, 32'h4);

    // redirect in the grant cycle, then misaligned redirect, then PC wrap
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 1'b0);
    chk("t3_req_at_redirect", 32'(s_req), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_flush_valid", 32'(s_valid), 32'd0);
    chk("t3_flush_req", 32'(s_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_req", 32'(s_req), 32'd1);
    chk("t3_addr", s_addr, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h203, 1'b0);
    chk("t3_valid", 32'(s_valid), 32'd1);
    chk("t3_pc", s_pc, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t4_misalign", 32'(s_mis), 32'd1);
    chk("t4_addr", s_addr, 32'h200);
    chk("t4_valid", 32'(s_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t4_misalign_pulse", 32'(s_mis), 32'd0);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("t4_pc", s_pc, 32'h200);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_addr", s_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_pc", s_pc, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_wrap_req", 32'(s_req), 32'd1);
    chk("t5_wrap_addr", s_addr, 32'h0);

    // reset while a read is outstanding, then while holding
    for (int w = 1; w <= 2; w++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      run_until(w, "t6_state");
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t6_valid", 32'(s_valid), 32'd0);
      chk("t6_instr", s_instr, 32'h0);
      chk("t6_req", 32'(s_req), 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t6_first_req", 32'(s_req), 32'd1);
      chk("t6_first_addr", s_addr, RST_PC);
    end

    // randomized traffic: grant gaps, variable latency, stalls, redirects, resets
    gnt_pct = 60;
    dly_max = 3;
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = $urandom();
      if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(15) == 0) rp = 32'hFFFF_FFFC;
      cyc($urandom_range(199) == 0, $urandom_range(99) < 8, rp, $urandom_range(99) < 40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
